// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter
//   Round-robin arbiter sharing one rggen register-bus port among HOSTS
//   requesters. The winning request is latched and held stable downstream
//   until the slave answers; the ready pulse is routed back to the winner
//   only, while status and read data are broadcast to every host slice.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_host_valid         per-host request valid                [HOSTS]
//   i_host_access        per-host access code                  [2*HOSTS]
//   i_host_address       per-host address                      [ADDRESS_WIDTH*HOSTS]
//   i_host_write_data    per-host write data                   [BUS_WIDTH*HOSTS]
//   i_host_strobe        per-host byte strobe                  [BUS_WIDTH/8*HOSTS]
//   o_host_ready         per-host completion pulse (combinational)
//   o_host_status        broadcast response status             [2*HOSTS]
//   o_host_read_data     broadcast read data                   [BUS_WIDTH*HOSTS]
//   o_bus_valid          downstream request valid (registered)
//   o_bus_access/address/write_data/strobe  latched payload
//   i_bus_ready, i_bus_status, i_bus_read_data  downstream response
module rggen_bus_arbiter #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [HOSTS-1:0]                 i_host_valid,
    input  logic [2*HOSTS-1:0]               i_host_access,
    input  logic [ADDRESS_WIDTH*HOSTS-1:0]   i_host_address,
    input  logic [BUS_WIDTH*HOSTS-1:0]       i_host_write_data,
    input  logic [BUS_WIDTH/8*HOSTS-1:0]     i_host_strobe,
    output logic [HOSTS-1:0]                 o_host_ready,
    output logic [2*HOSTS-1:0]               o_host_status,
    output logic [BUS_WIDTH*HOSTS-1:0]       o_host_read_data,
    output logic                             o_bus_valid,
    output logic [1:0]                       o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
    output logic [BUS_WIDTH-1:0]             o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_bus_strobe,
    input  logic                             i_bus_ready,
    input  logic [1:0]                       i_bus_status,
    input  logic [BUS_WIDTH-1:0]             i_bus_read_data
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int IDX_W  = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_load;
    logic                       w_done;

    logic [HOSTS-1:0]           r_grant;
    logic [IDX_W-1:0]           r_last;

    logic [1:0]                 r_access;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic [BUS_WIDTH-1:0]       r_write_data;
    logic [STRB_W-1:0]          r_strobe;

    logic [HOSTS-1:0]           w_sel_grant;
    logic [IDX_W-1:0]           w_sel_idx;
    logic                       w_found;
    logic [IDX_W-1:0]           w_cand;

    logic [1:0]                 w_access;
    logic [ADDRESS_WIDTH-1:0]   w_address;
    logic [BUS_WIDTH-1:0]       w_write_data;
    logic [STRB_W-1:0]          w_strobe;

    // Round-robin search: start one past the last winner and wrap, so the
    // last winner has the lowest priority in the next arbitration.
    always_comb begin
        w_sel_grant = '0;
        w_sel_idx   = r_last;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int i = 1; i <= HOSTS; i++) begin
            w_cand = IDX_W'((int'(r_last) + i) % HOSTS);
            if (!w_found && i_host_valid[w_cand]) begin
                w_found             = 1'b1;
                w_sel_idx           = w_cand;
                w_sel_grant[w_cand] = 1'b1;
            end
        end
    end

    // One-hot payload mux for the selected host.
    always_comb begin
        w_access     = '0;
        w_address    = '0;
        w_write_data = '0;
        w_strobe     = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (w_sel_grant[h]) begin
                w_access     = i_host_access[2*h +: 2];
                w_address    = i_host_address[ADDRESS_WIDTH*h +: ADDRESS_WIDTH];
                w_write_data = i_host_write_data[BUS_WIDTH*h +: BUS_WIDTH];
                w_strobe     = i_host_strobe[STRB_W*h +: STRB_W];
            end
        end
    end

    // Next-state logic. Bus ready is only meaningful while BUSY.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_host_valid) begin
                    w_load       = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (i_bus_ready) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, pointer and payload. The payload is captured only on the
    // arbitration edge, so host inputs are ignored for the whole BUSY phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant      <= '0;
            r_last       <= IDX_W'(HOSTS - 1);
            r_access     <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_strobe     <= '0;
        end else if (w_load) begin
            r_grant      <= w_sel_grant;
            r_last       <= w_sel_idx;
            r_access     <= w_access;
            r_address    <= w_address;
            r_write_data <= w_write_data;
            r_strobe     <= w_strobe;
        end else if (w_done) begin
            r_grant      <= '0;
        end
    end

    assign o_bus_valid      = (r_state == BUSY);
    assign o_bus_access     = r_access;
    assign o_bus_address    = r_address;
    assign o_bus_write_data = r_write_data;
    assign o_bus_strobe     = r_strobe;

    assign o_host_ready     = r_grant & {HOSTS{w_done}};
    assign o_host_status    = {HOSTS{i_bus_status}};
    assign o_host_read_data = {HOSTS{i_bus_read_data}};

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb_rggen_bus_arbiter
//   Directed bench for rggen_bus_arbiter with three hosts. Each scenario
//   drives inputs just after the rising edge and checks outputs a little
//   later in the same cycle against hand-computed values.
module tb_rggen_bus_arbiter;

    localparam int HOSTS = 3;
    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int SW    = BW / 8;

    logic                  clk;
    logic                  rst_n;
    logic [HOSTS-1:0]      host_valid;
    logic [2*HOSTS-1:0]    host_access;
    logic [AW*HOSTS-1:0]   host_address;
    logic [BW*HOSTS-1:0]   host_write_data;
    logic [SW*HOSTS-1:0]   host_strobe;
    logic [HOSTS-1:0]      host_ready;
    logic [2*HOSTS-1:0]    host_status;
    logic [BW*HOSTS-1:0]   host_read_data;
    logic                  bus_valid;
    logic [1:0]            bus_access;
    logic [AW-1:0]         bus_address;
    logic [BW-1:0]         bus_write_data;
    logic [SW-1:0]         bus_strobe;
    logic                  bus_ready;
    logic [1:0]            bus_status;
    logic [BW-1:0]         bus_read_data;

    int n_cmp;
    int n_err;

    rggen_bus_arbiter #(
        .HOSTS         (HOSTS),
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW)
    ) u_dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_host_valid      (host_valid),
        .i_host_access     (host_access),
        .i_host_address    (host_address),
        .i_host_write_data (host_write_data),
        .i_host_strobe     (host_strobe),
        .o_host_ready      (host_ready),
        .o_host_status     (host_status),
        .o_host_read_data  (host_read_data),
        .o_bus_valid       (bus_valid),
        .o_bus_access      (bus_access),
        .o_bus_address     (bus_address),
        .o_bus_write_data  (bus_write_data),
        .o_bus_strobe      (bus_strobe),
        .i_bus_ready       (bus_ready),
        .i_bus_status      (bus_status),
        .i_bus_read_data   (bus_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_host(input int h, input logic [1:0] acc, input logic [AW-1:0] addr,
                            input logic [BW-1:0] wd, input logic [SW-1:0] strb);
        host_access[2*h +: 2]       = acc;
        host_address[AW*h +: AW]    = addr;
        host_write_data[BW*h +: BW] = wd;
        host_strobe[SW*h +: SW]     = strb;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        host_valid      = '0;
        host_access     = '0;
        host_address    = '0;
        host_write_data = '0;
        host_strobe     = '0;
        bus_ready       = 1'b0;
        bus_status      = 2'b00;
        bus_read_data   = '0;

        // Reset state
        #12;
        chk("rst_valid", 64'(bus_valid), 64'd0);
        chk("rst_addr", 64'(bus_address), 64'h0);
        chk("rst_ready", 64'(host_ready), 64'd0);
        rst_n = 1'b1;
        tick;

        // Single request: host0 read 0x10, slave ready after one BUSY cycle
        set_host(0, 2'b10, 8'h10, 32'h0, 4'hF);
        host_valid = 3'b001;
        #1;
        chk("single_idle_valid", 64'(bus_valid), 64'd0);
        tick;
        chk("single_valid", 64'(bus_valid), 64'd1);
        chk("single_addr", 64'(bus_address), 64'h10);
        chk("single_access", 64'(bus_access), 64'h2);
        chk("single_no_ready", 64'(host_ready), 64'd0);
        tick;
        bus_ready     = 1'b1;
        bus_read_data = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(host_ready), 64'b001);
        chk("single_rdata", 64'(host_read_data[0 +: BW]), 64'hDEADBEEF);
        host_valid = 3'b000;
        tick;
        bus_ready = 1'b0;
        #1;
        chk("single_idle_after", 64'(bus_valid), 64'd0);
        chk("single_ready_off", 64'(host_ready), 64'd0);

        // Simultaneous host0/host1 after reset
        do_reset;
        tick;
        set_host(0, 2'b11, 8'h20, 32'h11112222, 4'h3);
        set_host(1, 2'b10, 8'h30, 32'h0, 4'hF);
        host_valid = 3'b011;
        tick;
        chk("sim_first_addr", 64'(bus_address), 64'h20);
        chk("sim_first_wdata", 64'(bus_write_data), 64'h11112222);
        chk("sim_first_strb", 64'(bus_strobe), 64'h3);
        bus_ready = 1'b1;
        #1;
        chk("sim_first_ready", 64'(host_ready), 64'b001);
        host_valid = 3'b010;
        tick;
        bus_ready = 1'b0;
        #1;
        chk("sim_gap_valid", 64'(bus_valid), 64'd0);
        chk("sim_gap_addr", 64'(bus_address), 64'h20);
        tick;
        chk("sim_second_valid", 64'(bus_valid), 64'd1);
        chk("sim_second_addr", 64'(bus_address), 64'h30);
        bus_ready = 1'b1;
        #1;
        chk("sim_second_ready", 64'(host_ready), 64'b010);
        host_valid = 3'b000;
        tick;
        bus_ready = 1'b0;

        // Fairness: all three hosts request continuously, 0-wait slave
        do_reset;
        tick;
        set_host(0, 2'b10, 8'hA0, 32'h0, 4'hF);
        set_host(1, 2'b10, 8'hA1, 32'h0, 4'hF);
        set_host(2, 2'b10, 8'hA2, 32'h0, 4'hF);
        host_valid = 3'b111;
        bus_ready  = 1'b1;
        #1;
        chk("fair_idle_ready_ignored", 64'(host_ready), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("fair_valid_%0d", k), 64'(bus_valid), 64'd1);
            chk($sformatf("fair_grant_%0d", k), 64'(host_ready), 64'(3'b001 << (k % 3)));
            chk($sformatf("fair_addr_%0d", k), 64'(bus_address), 64'(8'hA0 + k % 3));
            tick;
            chk($sformatf("fair_gap_%0d", k), 64'(bus_valid), 64'd0);
            chk($sformatf("fair_gap_ready_%0d", k), 64'(host_ready), 64'd0);
        end
        host_valid = 3'b000;
        bus_ready  = 1'b0;
        tick;

        // Wait states with a host changing its address mid-flight
        set_host(1, 2'b11, 8'h44, 32'hCAFEF00D, 4'hC);
        host_valid = 3'b010;
        tick;
        set_host(1, 2'b10, 8'h99, 32'h0, 4'h1);
        set_host(0, 2'b10, 8'h0B, 32'h0, 4'hF);
        host_valid = 3'b011;
        for (int w = 0; w < 5; w++) begin
            #1;
            chk($sformatf("ws_valid_%0d", w), 64'(bus_valid), 64'd1);
            chk($sformatf("ws_addr_%0d", w), 64'(bus_address), 64'h44);
            chk($sformatf("ws_no_ready_%0d", w), 64'(host_ready), 64'd0);
            tick;
        end
        chk("ws_wdata_frozen", 64'(bus_write_data), 64'hCAFEF00D);
        bus_ready  = 1'b1;
        bus_status = 2'b01;
        #1;
        chk("ws_ready_granted_only", 64'(host_ready), 64'b010);
        chk("ws_status_bcast", 64'(host_status), 64'b010101);
        host_valid = 3'b001;
        tick;
        bus_ready  = 1'b0;
        bus_status = 2'b00;
        tick;
        chk("ws_next_addr", 64'(bus_address), 64'h0B);
        bus_ready = 1'b1;
        #1;
        chk("ws_next_ready", 64'(host_ready), 64'b001);
        host_valid = 3'b000;
        tick;
        bus_ready = 1'b0;

        // Reset in the middle of a transaction
        set_host(1, 2'b10, 8'h55, 32'h0, 4'hF);
        host_valid = 3'b010;
        tick;
        chk("mid_busy", 64'(bus_valid), 64'd1);
        bus_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("mid_valid_drop", 64'(bus_valid), 64'd0);
        chk("mid_addr_clear", 64'(bus_address), 64'h0);
        chk("mid_ready_none", 64'(host_ready), 64'd0);
        host_valid = 3'b000;
        #1;
        rst_n = 1'b1;
        tick;
        chk("mid_stray_ready", 64'(host_ready), 64'd0);
        chk("mid_stray_idle", 64'(bus_valid), 64'd0);
        set_host(0, 2'b10, 8'h60, 32'h0, 4'hF);
        set_host(1, 2'b10, 8'h61, 32'h0, 4'hF);
        set_host(2, 2'b10, 8'h62, 32'h0, 4'hF);
        host_valid = 3'b111;
        tick;
        chk("mid_prio_addr", 64'(bus_address), 64'h60);
        #1;
        chk("mid_prio_ready", 64'(host_ready), 64'b001);
        host_valid = 3'b000;
        tick;
        bus_ready = 1'b0;

        // Misuse: granted host drops valid while BUSY
        set_host(2, 2'b11, 8'h77, 32'h12345678, 4'hF);
        host_valid = 3'b100;
        tick;
        host_valid = 3'b000;
        tick;
        chk("drop_valid_hold1", 64'(bus_valid), 64'd1);
        tick;
        chk("drop_valid_hold2", 64'(bus_valid), 64'd1);
        chk("drop_addr", 64'(bus_address), 64'h77);
        bus_ready = 1'b1;
        #1;
        chk("drop_ready", 64'(host_ready), 64'b100);
        tick;
        bus_ready = 1'b0;
        #1;
        chk("drop_idle", 64'(bus_valid), 64'd0);
        chk("drop_ready_off", 64'(host_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
